// File: rtl/risc_controller_if.sv
// risc_controller_if: opcode/zero inputs and datapath strobes of the RISC sequencer.
// CTRL_RESUME_EN adds the go resume input.
`default_nettype none

interface risc_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       data_e;
  logic       wr;
  logic       ldac;
  logic       halt;
`ifdef CTRL_RESUME_EN
  logic       go;

  modport master (
    input  opcode, zero, go,
    output sel, rd, ld_ir, inc_pc, ld_pc, data_e, wr, ldac, halt
  );
  modport slave (
    output opcode, zero, go,
    input  sel, rd, ld_ir, inc_pc, ld_pc, data_e, wr, ldac, halt
  );
`else
  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, data_e, wr, ldac, halt
  );
  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, data_e, wr, ldac, halt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/risc_controller.sv
// risc_controller: eight-phase instruction sequencer driving all datapath strobes.
// Optional macro CTRL_RESUME_EN: go input releases a halt (otherwise halt is sticky until rst).
`default_nettype none

module risc_controller #(
  parameter int START_PHASE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  risc_controller_if.master        bus
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] START_BITS = START_PHASE[2:0];
  localparam phase_t     START_ST   = phase_t'(START_BITS);

  phase_t r_phase;
  phase_t w_next_phase;
  logic   r_halted;
  logic   w_next_halted;
  logic   w_alu_op;
  logic   w_is_hlt;
  logic   w_is_skz;
  logic   w_is_sto;
  logic   w_is_jmp;
  logic   w_go;

`ifdef CTRL_RESUME_EN
  assign w_go = bus.go;
`else
  assign w_go = 1'b0;
`endif

  assign w_alu_op = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                    (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
  assign w_is_hlt = (bus.opcode == OP_HLT);
  assign w_is_skz = (bus.opcode == OP_SKZ);
  assign w_is_sto = (bus.opcode == OP_STO);
  assign w_is_jmp = (bus.opcode == OP_JMP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= START_ST;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_next_phase;
      r_halted <= w_next_halted;
    end
  end

  // Next-state: a halt freezes the phase at OP_ADDR until go (if built in) or reset.
  always_comb begin
    w_next_phase  = phase_t'(r_phase + 3'd1);
    w_next_halted = r_halted;
    if (r_halted) begin
      w_next_phase = r_phase;
      if (w_go) begin
        w_next_phase  = PH_OP_FETCH;
        w_next_halted = 1'b0;
      end
    end else begin
      case (r_phase)
        PH_OP_ADDR: begin
          if (w_is_hlt) begin
            w_next_phase  = r_phase;
            w_next_halted = 1'b1;
          end
        end
        PH_STORE: w_next_phase = START_ST;
        default:  ;
      endcase
    end
  end

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.data_e = 1'b0;
    bus.wr     = 1'b0;
    bus.ldac   = 1'b0;
    bus.halt   = 1'b0;
    if (r_halted) begin
      bus.halt   = 1'b1;
      bus.inc_pc = w_go;
    end else begin
      case (r_phase)
        PH_INST_ADDR: begin
          bus.sel = 1'b1;
        end
        PH_INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          bus.inc_pc = !w_is_hlt;
          bus.halt   = w_is_hlt;
        end
        PH_OP_FETCH: begin
          bus.rd = w_alu_op;
        end
        PH_ALU_OP: begin
          bus.rd     = w_alu_op;
          bus.inc_pc = w_is_skz && bus.zero;
          bus.ld_pc  = w_is_jmp;
          bus.data_e = w_is_sto;
        end
        PH_STORE: begin
          bus.rd     = w_alu_op;
          bus.ldac   = w_alu_op;
          bus.ld_pc  = w_is_jmp;
          bus.inc_pc = w_is_jmp;
          bus.wr     = w_is_sto;
          bus.data_e = w_is_sto;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed per-phase vectors pushed to a scoreboard, checked on the falling edge.
`default_nettype none

module tb_risc_controller;

  // bit order: sel rd ld_ir inc_pc ld_pc data_e wr ldac halt
  localparam logic [8:0] E_RST  = 9'b100000000;
  localparam logic [8:0] E_P0   = 9'b100000000;
  localparam logic [8:0] E_P1   = 9'b110000000;
  localparam logic [8:0] E_P2   = 9'b111000000;
  localparam logic [8:0] E_INC  = 9'b000100000;
  localparam logic [8:0] E_RD   = 9'b010000000;
  localparam logic [8:0] E_LDAC = 9'b010000010;
  localparam logic [8:0] E_NONE = 9'b000000000;
  localparam logic [8:0] E_STO6 = 9'b000001000;
  localparam logic [8:0] E_STO7 = 9'b000001100;
  localparam logic [8:0] E_JMP6 = 9'b000010000;
  localparam logic [8:0] E_JMP7 = 9'b000110000;
  localparam logic [8:0] E_HALT = 9'b000000001;
  localparam logic [8:0] E_GO   = 9'b000100001;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                         XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  risc_controller_if bus();

  risc_controller #(.START_PHASE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t       e;
      logic [8:0] act;
      e   = sb.pop_front();
      act = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
             bus.data_e, bus.wr, bus.ldac, bus.halt};
      n_vec++;
      if (act !== e.v) begin
        n_err++;
        $display("FAIL %s: strobes got %b, expected %b (t=%0t)", e.tag, act, e.v, $time);
      end
    end
  end

  task automatic step(input logic [2:0] op, input logic z, input logic [8:0] e, input string tag);
    bus.opcode = op;
    bus.zero   = z;
    sb.push_back('{v: e, tag: tag});
    @(posedge clk);
    #1;
  endtask

  // Fetch phases carry random opcode/zero: they must be ignored there.
  task automatic fetch(input string tag);
    step(3'($urandom), 1'($urandom), E_P0, {tag, "_ph0"});
    step(3'($urandom), 1'($urandom), E_P1, {tag, "_ph1"});
    step(3'($urandom), 1'($urandom), E_P2, {tag, "_ph2"});
    step(3'($urandom), 1'($urandom), E_P2, {tag, "_ph3"});
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7,
                           input string tag);
    fetch(tag);
    step(op, 1'($urandom), e4, {tag, "_ph4"});
    step(op, 1'($urandom), e5, {tag, "_ph5"});
    step(op, z,            e6, {tag, "_ph6"});
    step(op, 1'($urandom), e7, {tag, "_ph7"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode = ADD;
    bus.zero   = 1'b0;
`ifdef CTRL_RESUME_EN
    bus.go     = 1'b0;
`endif
    @(posedge clk);
    #1;
    step(ADD, 1'b0, E_RST, "reset");
    step(ADD, 1'b0, E_RST, "reset_hold");
    rst = 1'b1;

    run_instr(ADD,  1'b0, E_INC, E_RD,   E_RD,   E_LDAC, "add");
    run_instr(AND_, 1'b1, E_INC, E_RD,   E_RD,   E_LDAC, "and");
    run_instr(XOR_, 1'b0, E_INC, E_RD,   E_RD,   E_LDAC, "xor");
    run_instr(STO,  1'b1, E_INC, E_NONE, E_STO6, E_STO7, "sto");
    run_instr(SKZ,  1'b1, E_INC, E_NONE, E_INC,  E_NONE, "skz_z1");
    run_instr(SKZ,  1'b0, E_INC, E_NONE, E_NONE, E_NONE, "skz_z0");
    run_instr(JMP,  1'b0, E_INC, E_NONE, E_JMP6, E_JMP7, "jmp");
    run_instr(LDA,  1'b1, E_INC, E_RD,   E_RD,   E_LDAC, "lda");

    // Asynchronous reset in the middle of ALU_OP of an LDA.
    fetch("lda_rst");
    step(LDA, 1'b0, E_INC, "lda_rst_ph4");
    step(LDA, 1'b0, E_RD,  "lda_rst_ph5");
    bus.opcode = LDA;
    #2;
    rst = 1'b0;
    sb.push_back('{v: E_RST, tag: "async_rst"});
    @(posedge clk);
    #1;
    step(LDA, 1'b0, E_RST, "async_rst_hold");
    rst = 1'b1;
    run_instr(ADD, 1'b0, E_INC, E_RD, E_RD, E_LDAC, "add_after_rst");

    // Halt: frozen with only halt asserted, whatever the opcode does.
    fetch("hlt");
    step(HLT, 1'b0, E_HALT, "hlt_ph4");
    for (int i = 0; i < 20; i++)
      step(3'($urandom), 1'($urandom), E_HALT, "halted");
`ifdef CTRL_RESUME_EN
    bus.go = 1'b1;
    step(HLT, 1'b0, E_GO, "resume_go");
    bus.go = 1'b0;
    step(ADD, 1'b0, E_RD,   "resume_ph5");
    step(ADD, 1'b0, E_RD,   "resume_ph6");
    step(ADD, 1'b0, E_LDAC, "resume_ph7");
    step(ADD, 1'b0, E_P0,   "resume_ph0");
`else
    step(HLT, 1'b0, E_HALT, "halted_sticky");
    rst = 1'b0;
    step(ADD, 1'b0, E_RST, "hlt_reset");
    rst = 1'b1;
    run_instr(ADD, 1'b0, E_INC, E_RD, E_RD, E_LDAC, "add_after_hlt");
`endif

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
